// File: rtl/write_through_buffer.sv
`default_nettype none
// ============================================================================
// Module      : write_through_buffer
// Description : Posted-write FIFO ahead of the write channel; oldest entry is
//               offered over valid/ready, empty lets reads wait for drain.
// Revision    : 1.0 - initial release
// ============================================================================
module write_through_buffer #(
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32,
    parameter int FE_NBYTES = FE_DATA_W / 8,
    parameter int FE_BYTE_W = $clog2(FE_NBYTES),
    parameter int DEPTH_W   = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [FE_ADDR_W-FE_BYTE_W-1:0] push_addr,
    input  logic [FE_DATA_W-1:0]           push_wdata,
    input  logic [FE_NBYTES-1:0]           push_wstrb,
    output logic                           full,
    output logic                           empty,
    output logic [DEPTH_W:0]               level,
    output logic                           overflow,
    output logic                           wc_valid,
    input  logic                           wc_ready,
    output logic [FE_ADDR_W-FE_BYTE_W-1:0] wc_addr,
    output logic [FE_DATA_W-1:0]           wc_wdata,
    output logic [FE_NBYTES-1:0]           wc_wstrb
);

    localparam int c_addr_w  = FE_ADDR_W - FE_BYTE_W;
    localparam int c_entry_w = c_addr_w + FE_DATA_W + FE_NBYTES;
    localparam int c_depth   = 2 ** DEPTH_W;
    localparam logic [DEPTH_W:0]   c_full_level = (DEPTH_W+1)'(c_depth);
    localparam logic [DEPTH_W:0]   c_level_one  = (DEPTH_W+1)'(1);
    localparam logic [DEPTH_W-1:0] c_ptr_one    = DEPTH_W'(1);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [c_entry_w-1:0] r_mem [c_depth];
    logic [DEPTH_W-1:0]   r_wptr;
    logic [DEPTH_W-1:0]   r_rptr;
    logic [DEPTH_W:0]     r_level;
    logic                 r_overflow;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    // Assertion follows reset_n immediately; release is aligned to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign empty    = (r_level == '0);
    assign full     = (r_level == c_full_level);
    assign level    = r_level;
    assign overflow = r_overflow;
    assign wc_valid = !empty;

    assign w_push_ok = push && !full;
    assign w_pop_ok  = wc_valid && wc_ready;

    assign {wc_addr, wc_wdata, wc_wstrb} = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= {push_addr, push_wdata, push_wstrb};
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            // A push arriving while full is refused even if a pop frees a slot.
            if (push && full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_level_one;
                2'b01:   r_level <= r_level - c_level_one;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_write_through_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_through_buffer
// Description : Directed self-checking bench for write_through_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_through_buffer;

    localparam int c_addr_w = 30;

    logic                clk;
    logic                reset_n;
    logic                push;
    logic [c_addr_w-1:0] push_addr;
    logic [31:0]         push_wdata;
    logic [3:0]          push_wstrb;
    logic                full;
    logic                empty;
    logic [2:0]          level;
    logic                overflow;
    logic                wc_valid;
    logic                wc_ready;
    logic [c_addr_w-1:0] wc_addr;
    logic [31:0]         wc_wdata;
    logic [3:0]          wc_wstrb;

    int checks;
    int errors;

    write_through_buffer #(
        .FE_ADDR_W(32),
        .FE_DATA_W(32),
        .DEPTH_W  (2)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_addr (push_addr),
        .push_wdata(push_wdata),
        .push_wstrb(push_wstrb),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .wc_valid  (wc_valid),
        .wc_ready  (wc_ready),
        .wc_addr   (wc_addr),
        .wc_wdata  (wc_wdata),
        .wc_wstrb  (wc_wstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_push(input logic en, input logic [31:0] data);
        push       = en;
        push_addr  = c_addr_w'(data);
        push_wdata = data;
        push_wstrb = 4'hF;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        wc_ready = 1'b0;
        set_push(1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();

        // Reset state, then idle
        for (int i = 0; i < 2; i++) begin
            check("rst_empty", 64'(empty), 64'd1);
            check("rst_full", 64'(full), 64'd0);
            check("rst_level", 64'(level), 64'd0);
            check("rst_valid", 64'(wc_valid), 64'd0);
            check("rst_ovf", 64'(overflow), 64'd0);
            step();
        end

        // Single entry: byte address 0x10 -> word address 0x4
        push       = 1'b1;
        push_addr  = 30'h4;
        push_wdata = 32'hDEADBEEF;
        push_wstrb = 4'hF;
        step();
        set_push(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("single_valid", 64'(wc_valid), 64'd1);
            check("single_addr", 64'(wc_addr), 64'h4);
            check("single_data", 64'(wc_wdata), 64'hDEADBEEF);
            check("single_strb", 64'(wc_wstrb), 64'hF);
            check("single_level", 64'(level), 64'd1);
            step();
        end
        wc_ready = 1'b1;
        step();
        wc_ready = 1'b0;
        check("single_empty", 64'(empty), 64'd1);
        check("single_novalid", 64'(wc_valid), 64'd0);

        // Fill and overflow
        for (int i = 1; i <= 4; i++) begin
            set_push(1'b1, 32'(i));
            step();
        end
        check("fill_full", 64'(full), 64'd1);
        check("fill_level", 64'(level), 64'd4);
        check("fill_noovf", 64'(overflow), 64'd0);
        set_push(1'b1, 32'd5);
        step();
        set_push(1'b0, 32'h0);
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_level", 64'(level), 64'd4);
        wc_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", 64'(wc_valid), 64'd1);
            check("drain_data", 64'(wc_wdata), 64'(i));
            check("drain_addr", 64'(wc_addr), 64'(i));
            step();
        end
        wc_ready = 1'b0;
        check("drain_done", 64'(wc_valid), 64'd0);
        check("drain_ovf_sticky", 64'(overflow), 64'd1);

        // Simultaneous push and pop at level 2 across pointer wraps
        set_push(1'b1, 32'd10);
        step();
        set_push(1'b1, 32'd11);
        step();
        check("sim_level0", 64'(level), 64'd2);
        for (int i = 0; i < 10; i++) begin
            set_push(1'b1, 32'(12 + i));
            wc_ready = 1'b1;
            check("sim_head", 64'(wc_wdata), 64'(10 + i));
            step();
            check("sim_level", 64'(level), 64'd2);
        end
        set_push(1'b0, 32'h0);
        wc_ready = 1'b0;
        check("sim_tail", 64'(wc_wdata), 64'd20);

        do_reset();
        check("rst2_level", 64'(level), 64'd0);
        check("rst2_ovf", 64'(overflow), 64'd0);

        // Full plus simultaneous pop: push is still refused
        for (int i = 30; i <= 33; i++) begin
            set_push(1'b1, 32'(i));
            step();
        end
        check("fp_full", 64'(full), 64'd1);
        set_push(1'b1, 32'd34);
        wc_ready = 1'b1;
        check("fp_head", 64'(wc_wdata), 64'd30);
        step();
        set_push(1'b0, 32'h0);
        wc_ready = 1'b0;
        check("fp_level", 64'(level), 64'd3);
        check("fp_ovf", 64'(overflow), 64'd1);
        check("fp_next", 64'(wc_wdata), 64'd31);

        // Asynchronous reset mid-drain, observed before the next edge
        #2;
        reset_n = 1'b0;
        #1;
        check("ares_valid", 64'(wc_valid), 64'd0);
        check("ares_level", 64'(level), 64'd0);
        check("ares_empty", 64'(empty), 64'd1);
        check("ares_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        set_push(1'b1, 32'hA5);
        step();
        set_push(1'b0, 32'h0);
        check("post_valid", 64'(wc_valid), 64'd1);
        check("post_data", 64'(wc_wdata), 64'hA5);
        check("post_level", 64'(level), 64'd1);
        wc_ready = 1'b1;
        step();
        wc_ready = 1'b0;
        check("post_empty", 64'(empty), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
